// File: rtl/button_events.sv
// Turns one debounced button level into single-cycle press, click, long,
// repeat and release events plus a held level; one instance per button.
module button_events #(
    parameter int CLK_FREQ  = 25000000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic signal_i,
    output logic press_o,
    output logic click_o,
    output logic long_o,
    output logic repeat_o,
    output logic release_o,
    output logic held_o
);

    localparam int TICKS_PER_MS = CLK_FREQ / 1000;
    localparam int LONG_TICKS   = TICKS_PER_MS * LONG_MS;
    localparam int REP_TICKS    = TICKS_PER_MS * REPEAT_MS;
    localparam int MAX_TICKS    =
        (LONG_TICKS > REP_TICKS) ? LONG_TICKS : REP_TICKS;
    localparam int CW           = $clog2(MAX_TICKS + 1);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_TICKS - 1);

    if (LONG_TICKS < 2) begin : g_bad_long
        $error("button_events: LONG_TICKS must be at least 2");
    end
    if (REP_TICKS < 1) begin : g_bad_rep
        $error("button_events: REP_TICKS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sig_q;
    logic          press_q, press_d;
    logic          click_q, click_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          release_q, release_d;
    logic          held_q, held_d;
    logic          rise;

    assign rise = signal_i & ~sig_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        release_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            PRESS: begin
                if (!signal_i) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    click_d   = 1'b1;
                    release_d = 1'b1;
                end else if (press_q) begin
                    // The press cycle is not counted, so long_o lands
                    // LONG_TICKS+1 cycles after press_o.
                    cnt_d = cnt_q;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!signal_i) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            // Start "high" so a button held through reset is ignored.
            sig_q     <= 1'b1;
            press_q   <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sig_q     <= signal_i;
            press_q   <= press_d;
            click_q   <= click_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            release_q <= release_d;
            held_q    <= held_d;
        end
    end

    assign press_o   = press_q;
    assign click_o   = click_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;
    assign release_o = release_q;
    assign held_o    = held_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: LONG_TICKS=100, REP_TICKS=50.
// Events are timestamped by a monitor and compared to hand-derived cycles.
module tb_button_events;

    logic clk = 1'b0;
    logic rst_ni;
    logic signal_i;
    logic press_o, click_o, long_o, repeat_o, release_o, held_o;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int n_press, n_click, n_long, n_rep, n_rel, n_held;
    int t_press, t_click, t_long, t_rel, t_rep_first, t_rep_last;

    button_events #(
        .CLK_FREQ (10000),
        .LONG_MS  (10),
        .REPEAT_MS(5)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .signal_i (signal_i),
        .press_o  (press_o),
        .click_o  (click_o),
        .long_o   (long_o),
        .repeat_o (repeat_o),
        .release_o(release_o),
        .held_o   (held_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (press_o) begin n_press++; t_press = cyc; end
        if (click_o) begin n_click++; t_click = cyc; end
        if (long_o) begin n_long++; t_long = cyc; end
        if (release_o) begin n_rel++; t_rel = cyc; end
        if (held_o) n_held++;
        if (repeat_o) begin
            if (n_rep == 0) t_rep_first = cyc;
            t_rep_last = cyc;
            n_rep++;
        end
    end

    task automatic clear_counts();
        n_press = 0; n_click = 0; n_long = 0;
        n_rep = 0; n_rel = 0; n_held = 0;
        t_press = -1; t_click = -1; t_long = -1;
        t_rel = -1; t_rep_first = -1; t_rep_last = -1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        signal_i = 1'b1;
        #1;
        n_cmp++;
        if ({press_o, click_o, long_o, repeat_o, release_o, held_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000",
                {press_o, click_o, long_o, repeat_o, release_o, held_o});
        end
        cycles(3);
        rst_ni = 1'b1;
        clear_counts();
        cycles(500);
        n_cmp++;
        if (n_press + n_click + n_long + n_rep + n_rel !== 0) begin
            n_err++;
            $display("FAIL held_through_reset: events=%0d want 0",
                n_press + n_click + n_long + n_rep + n_rel);
        end
        n_cmp++;
        if (held_o !== 1'b0) begin
            n_err++;
            $display("FAIL held_through_reset_held: got %b want 0", held_o);
        end
        signal_i = 1'b0;
        cycles(2);
        signal_i = 1'b1;
        cycles(1);
        n_cmp++;
        if (press_o !== 1'b1 || held_o !== 1'b1) begin
            n_err++;
            $display("FAIL repress_after_reset: press=%b held=%b want 1 1",
                press_o, held_o);
        end
        cycles(1);
        n_cmp++;
        if (press_o !== 1'b0) begin
            n_err++;
            $display("FAIL press_width: got %b want 0", press_o);
        end
        signal_i = 1'b0;
        cycles(3);
    endtask

    task automatic test_short_press();
        clear_counts();
        signal_i = 1'b1;
        cycles(40);
        signal_i = 1'b0;
        cycles(5);
        n_cmp++;
        if (n_press !== 1 || n_click !== 1 || n_rel !== 1) begin
            n_err++;
            $display("FAIL short_counts: press=%0d click=%0d rel=%0d want 1 1 1",
                n_press, n_click, n_rel);
        end
        n_cmp++;
        if (n_long !== 0 || n_rep !== 0) begin
            n_err++;
            $display("FAIL short_no_long: long=%0d rep=%0d want 0 0",
                n_long, n_rep);
        end
        n_cmp++;
        if (n_held !== 40) begin
            n_err++;
            $display("FAIL short_held_len: got %0d want 40", n_held);
        end
        n_cmp++;
        if (t_rel - t_press !== 40 || t_click !== t_rel) begin
            n_err++;
            $display("FAIL short_timing: rel-press=%0d click=%0d rel=%0d want 40, equal",
                t_rel - t_press, t_click, t_rel);
        end
    endtask

    task automatic test_long_hold();
        clear_counts();
        signal_i = 1'b1;
        cycles(300);
        signal_i = 1'b0;
        cycles(5);
        n_cmp++;
        if (n_press !== 1 || n_long !== 1) begin
            n_err++;
            $display("FAIL hold_counts: press=%0d long=%0d want 1 1",
                n_press, n_long);
        end
        n_cmp++;
        if (t_long - t_press !== 101) begin
            n_err++;
            $display("FAIL long_latency: got %0d want 101", t_long - t_press);
        end
        n_cmp++;
        if (n_rep !== 3) begin
            n_err++;
            $display("FAIL repeat_count: got %0d want 3", n_rep);
        end
        n_cmp++;
        if (t_rep_first - t_long !== 50 || t_rep_last - t_long !== 150) begin
            n_err++;
            $display("FAIL repeat_timing: first=%0d last=%0d want 50 150",
                t_rep_first - t_long, t_rep_last - t_long);
        end
        n_cmp++;
        if (n_rel !== 1 || n_click !== 0 || t_rel - t_press !== 300) begin
            n_err++;
            $display("FAIL hold_release: rel=%0d click=%0d at=%0d want 1 0 300",
                n_rel, n_click, t_rel - t_press);
        end
        n_cmp++;
        if (n_held !== 300) begin
            n_err++;
            $display("FAIL hold_held_len: got %0d want 300", n_held);
        end
    endtask

    task automatic test_boundaries();
        clear_counts();
        signal_i = 1'b1;
        cycles(101);
        signal_i = 1'b0;
        cycles(4);
        n_cmp++;
        if (n_long !== 0 || n_click !== 1 || n_rel !== 1) begin
            n_err++;
            $display("FAIL press_edge: long=%0d click=%0d rel=%0d want 0 1 1",
                n_long, n_click, n_rel);
        end
        n_cmp++;
        if (t_rel - t_press !== 101 || t_click !== t_rel) begin
            n_err++;
            $display("FAIL press_edge_time: got %0d want 101", t_rel - t_press);
        end
        clear_counts();
        signal_i = 1'b1;
        cycles(151);
        signal_i = 1'b0;
        cycles(4);
        n_cmp++;
        if (n_long !== 1 || n_rep !== 0) begin
            n_err++;
            $display("FAIL hold_edge: long=%0d rep=%0d want 1 0", n_long, n_rep);
        end
        n_cmp++;
        if (n_rel !== 1 || n_click !== 0 || t_rel - t_press !== 151) begin
            n_err++;
            $display("FAIL hold_edge_rel: rel=%0d click=%0d at=%0d want 1 0 151",
                n_rel, n_click, t_rel - t_press);
        end
    endtask

    task automatic test_reset_mid_hold();
        clear_counts();
        signal_i = 1'b1;
        cycles(102);
        n_cmp++;
        if (long_o !== 1'b1 || held_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_long: long=%b held=%b want 1 1",
                long_o, held_o);
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({press_o, click_o, long_o, repeat_o, release_o, held_o} !== 6'b0) begin
            n_err++;
            $display("FAIL async_reset: got %b want 000000",
                {press_o, click_o, long_o, repeat_o, release_o, held_o});
        end
        cycles(3);
        rst_ni = 1'b1;
        clear_counts();
        cycles(200);
        n_cmp++;
        if (n_press + n_click + n_long + n_rep + n_rel + n_held !== 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: events=%0d want 0",
                n_press + n_click + n_long + n_rep + n_rel + n_held);
        end
        signal_i = 1'b0;
        cycles(2);
        signal_i = 1'b1;
        cycles(1);
        n_cmp++;
        if (press_o !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_press: got %b want 1", press_o);
        end
        signal_i = 1'b0;
        cycles(3);
    endtask

    task automatic test_glitch();
        signal_i = 1'b1;
        cycles(1);
        n_cmp++;
        if ({press_o, click_o, release_o, held_o} !== 4'b1001) begin
            n_err++;
            $display("FAIL glitch_press: press,click,rel,held=%b want 1001",
                {press_o, click_o, release_o, held_o});
        end
        signal_i = 1'b0;
        cycles(1);
        n_cmp++;
        if ({press_o, click_o, release_o, held_o} !== 4'b0110) begin
            n_err++;
            $display("FAIL glitch_release: press,click,rel,held=%b want 0110",
                {press_o, click_o, release_o, held_o});
        end
        cycles(2);
    endtask

    task automatic test_random();
        int viol = 0;
        int first = -1;
        clear_counts();
        signal_i = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 99) < 2) signal_i = ~signal_i;
            cycles(1);
            if ((int'(press_o) + int'(long_o) + int'(repeat_o)) > 1
                || (click_o && !release_o)) begin
                viol++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (viol !== 0) begin
            n_err++;
            $display("FAIL exclusivity: violations=%0d first_at=%0d want 0",
                viol, first);
        end
        signal_i = 1'b0;
        cycles(3);
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_short_press();
        test_long_hold();
        test_boundaries();
        test_reset_mid_hold();
        test_glitch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
